// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared types and constants for the SRAM request-side controller.
//   state_t   : controller state encoding
//   LAT_W     : width of the read-latency down-counter (RD_LAT up to 4)
//   CLEAR_VAL : fill value written by the clear sequence and used on reset
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    RSP   = 3'd3,
    CLEAR = 3'd4
  } state_t;

  localparam int LAT_W = 3;

  localparam int unsigned CLEAR_VAL = 0;

endpackage

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
// Request-side initiator for a single-port synchronous SRAM. Accepts one
// read or write at a time on a valid/ready request port, drives the SRAM
// pins, and returns read data on a valid/ready response port. Writes are
// posted (no response).
//
// Optional build macro: MEM_CLEAR_EN
//   When defined, the controller leaves reset in CLEAR and writes CLEAR_VAL
//   to every SRAM address (one per cycle) before accepting requests; the
//   sram_addr register doubles as the clear counter. init_busy is high
//   while this runs. When undefined, init_busy is tied 0.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_we                  1 = write, 0 = read
//   req_addr, req_wdata     request address / write data
//   rsp_valid/rsp_ready     read response handshake
//   rsp_rdata               read data
//   init_busy               clear sequence running
//   sram_we, sram_addr,
//   sram_wdata, sram_rdata  SRAM pin interface
//
// States:
//   state | meaning
//   IDLE  | ready for a request
//   WRITE | sram_we high for one cycle with registered addr/data
//   READ  | waiting RD_LAT cycles for sram_rdata
//   RSP   | holding read data until rsp_ready
//   CLEAR | filling the SRAM with CLEAR_VAL after reset
// ---------------------------------------------------------------------------
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_busy,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

`ifdef MEM_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t             state_q;
  state_t             state_d;
  logic [LAT_W-1:0]   lat_q;
  logic               we_q;

  // Gated with rst_n so the port is never ready while reset is held.
  assign req_ready = rst_n && (state_q == IDLE);

`ifdef MEM_CLEAR_EN
  // The clear write is driven straight from the state so the fill starts on
  // the first edge after release and finishes in exactly 2**ADDR_W cycles.
  // rst_n gating keeps the SRAM write strobe low while reset is asserted.
  assign init_busy = (state_q == CLEAR);
  assign sram_we   = we_q || (rst_n && (state_q == CLEAR));
`else
  assign init_busy = 1'b0;
  assign sram_we   = we_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = req_we ? WRITE : READ;
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        if (lat_q == '0) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
`ifdef MEM_CLEAR_EN
      CLEAR: begin
        if (sram_addr == '1) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= DATA_W'(CLEAR_VAL);
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      lat_q      <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            sram_addr <= req_addr;
            if (req_we) begin
              sram_wdata <= req_wdata;
              we_q       <= 1'b1;
            end else begin
              lat_q <= LAT_W'(RD_LAT);
            end
          end
        end
        READ: begin
          if (lat_q == '0) begin
            rsp_rdata <= sram_rdata;
            rsp_valid <= 1'b1;
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
`ifdef MEM_CLEAR_EN
        CLEAR: begin
          sram_wdata <= DATA_W'(CLEAR_VAL);
          if (sram_addr != '1) begin
            sram_addr <= sram_addr + ADDR_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl
// Self-checking bench for sram_ctrl with a behavioural SRAM attached to the
// pin interface and a reference word array tracking accepted writes.
// Honors MEM_CLEAR_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              init_busy;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] ref_mem [DEPTH];

  sram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .init_busy  (init_busy),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous SRAM: write on edge, read data RD_LAT edges later.
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    rd_pipe[0] <= mem[sram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_rdata = rd_pipe[RD_LAT-1];

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) until the request is accepted; returns #1 after that edge.
  task automatic wait_accept(input string tag);
    int cnt = 0;
    while (!req_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_accept_timeout"}, 32'(cnt < 50), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    wait_accept("wr");
    req_valid = 1'b0;
    ref_mem[a] = d;
    check("wr_we_high", 32'(sram_we), 32'd1);
    check("wr_addr", 32'(sram_addr), 32'(a));
    check("wr_data", sram_wdata, d);
    check("wr_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("wr_we_drop", 32'(sram_we), 32'd0);
    check("wr_ready_back", 32'(req_ready), 32'd1);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input int stall);
    int lat = 0;
    logic [DATA_W-1:0] exp_d;
    exp_d = ref_mem[a];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; rsp_ready = 1'b0;
    wait_accept("rd");
    req_valid = 1'b0;
    check("rd_we_low", 32'(sram_we), 32'd0);
    check("rd_addr", 32'(sram_addr), 32'(a));
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rd_latency", 32'(lat), 32'(RD_LAT + 1));
    check("rd_data", rsp_rdata, exp_d);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("bp_valid_hold", 32'(rsp_valid), 32'd1);
      check("bp_data_hold", rsp_rdata, exp_d);
      check("bp_ready_low", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("rsp_ready_back", 32'(req_ready), 32'd1);
  endtask

`ifdef MEM_CLEAR_EN
  // Called right after rst_n is released on a falling edge.
  task automatic wait_clear();
    int busy_cnt = 0;
    int we_cnt   = 0;
    int rdy_seen = 0;
    while (init_busy && busy_cnt < 1000) begin
      if (req_ready) rdy_seen++;
      if (sram_we) we_cnt++;
      busy_cnt++;
      @(negedge clk);
    end
    check("clr_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
    check("clr_we_cycles", 32'(we_cnt), 32'(DEPTH));
    check("clr_ready_seen", 32'(rdy_seen), 32'd0);
    check("clr_ready_after", 32'(req_ready), 32'd1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    #23;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_sram_we", 32'(sram_we), 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_sram_wdata", sram_wdata, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
`ifdef MEM_CLEAR_EN
    check("rst_init_busy", 32'(init_busy), 32'd1);
`else
    check("rst_init_busy", 32'(init_busy), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
`ifdef MEM_CLEAR_EN
    wait_clear();
`else
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
`endif

    // Basic write then read.
    do_write(8'h05, 32'hDEADBEEF);
    do_read(8'h05, 0);

    // Back-to-back writes with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 32'hA5A5_0010;
    wait_accept("b2b");
    ref_mem[8'h10] = 32'hA5A5_0010;
    check("b2b_first_we", 32'(sram_we), 32'd1);
    check("b2b_first_addr", 32'(sram_addr), 32'h10);
    req_addr = 8'h11; req_wdata = 32'h5A5A_0011;
    @(posedge clk); #1;
    check("b2b_gap_we", 32'(sram_we), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    ref_mem[8'h11] = 32'h5A5A_0011;
    check("b2b_second_we", 32'(sram_we), 32'd1);
    check("b2b_second_addr", 32'(sram_addr), 32'h11);
    check("b2b_second_data", sram_wdata, 32'h5A5A_0011);
    @(posedge clk); #1;
    check("b2b_end_we", 32'(sram_we), 32'd0);
    do_read(8'h10, 0);
    do_read(8'h11, 0);

    // Walking two-hot pattern over the whole array.
    for (int i = 0; i < DEPTH; i++) begin
      d = (32'd1 << (i % 32)) | (32'd1 << (31 - i % 32));
      do_write(ADDR_W'(i), d);
    end
    check("walk_addr3_model", ref_mem[3], 32'h1000_0008);
    for (int i = 0; i < DEPTH; i++) do_read(ADDR_W'(i), int'($urandom_range(0, 2)));

    // Random mix of reads and writes.
    for (int k = 0; k < 120; k++) begin
      a = ADDR_W'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom);
      else                            do_read(a, int'($urandom_range(0, 3)));
    end

    // Long backpressure.
    do_read(8'h05, 5);

    // Reset in the middle of a read.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05;
    wait_accept("rstmid");
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_sram_we", 32'(sram_we), 32'd0);
    check("rstmid_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef MEM_CLEAR_EN
    wait_clear();
`else
    #1;
    check("rstmid_ready_after", 32'(req_ready), 32'd1);
`endif
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("rstmid_no_stale_rsp", 32'(rsp_valid), 32'd0);
    end
    do_read(8'h05, 1);

`ifdef MEM_CLEAR_EN
    // Clear after reset wipes a previously written word.
    do_write(8'h80, 32'hFFFF_FFFF);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear();
    do_read(8'h80, 0);
    check("clr_addr80_model", ref_mem[8'h80], 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Request-side initiator for the single-port synchronous SRAM macro.
- Accepts read/write requests on a valid/ready port, drives the SRAM clk/WE/addr/data_in pins, and returns read data on a valid/ready response port.
- Sits between the CPU load/store path and the SRAM. It is the master end of the SRAM pin interface.

Parameters:
DATA_W, 32, word width; matches SRAM WIDTH
ADDR_W, 8, address width; SRAM LENGTH = 2**ADDR_W (256)
RD_LAT, 1, cycles from address presented to sram_rdata valid; legal range 1..4

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  read data valid
rsp_ready  in  1  consumer accepts read data
rsp_rdata  out  DATA_W  read data
init_busy  out  1  clear sequence running (MEM_CLEAR_EN only, else tied 0)
sram_we  out  1  SRAM write enable, active high
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM data_in
sram_rdata  in  DATA_W  SRAM data_out

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE (CLEAR if MEM_CLEAR_EN), sram_we=0, sram_addr=0, sram_wdata=0, rsp_valid=0, rsp_rdata=0, lat counter=0.
- req_ready is combinational: (state==IDLE). It is never high while rst_n=0.
- A handshake occurs at a rising edge where req_valid && req_ready. Requests are never queued. Only one transaction is in flight.
- IDLE->WRITE on an accepted write. sram_addr and sram_wdata are registered from the request, and sram_we=1 for exactly one cycle.
- WRITE->IDLE unconditionally. Writes are posted and produce no response. Maximum write throughput is 1 per 2 cycles.
- IDLE->READ on an accepted read. sram_addr is registered, sram_we stays 0, and the counter loads RD_LAT.
- READ: the counter decrements each cycle. When it reaches 0, sram_rdata is captured into rsp_rdata, rsp_valid is set to 1, and the state moves to RSP.
- Read timing: rsp_valid rises at edge accept+RD_LAT+1 (2 cycles after the accept edge for RD_LAT=1).
- RSP: rsp_valid and rsp_rdata are held stable while rsp_ready=0. On rsp_valid && rsp_ready: rsp_valid=0 and state->IDLE. There is no same-edge accept of a new request.
- sram_addr and sram_wdata hold their last values when idle. sram_we is 1 only in WRITE (and CLEAR).
- Address wrap: none needed; every ADDR_W value is a legal location.
- Reset mid-operation: all state and outputs are cleared asynchronously. sram_we drops immediately, so an in-flight write may or may not land. A pending read response is discarded.
- Illegal or unused state encodings recover to IDLE.

Optional Feature:
MEM_CLEAR_EN
- Defined: after rst_n release, state CLEAR writes 0 to addresses 0..2**ADDR_W-1, one per cycle with sram_we=1. During CLEAR, init_busy=1 and req_ready=0. After the last address, state->IDLE and init_busy=0. This takes exactly 2**ADDR_W cycles.
- Undefined: no CLEAR state, init_busy tied 0, IDLE directly out of reset.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - state enum: IDLE, WRITE, READ, RSP, CLEAR
  - RD_LAT counter width: localparam LAT_W=3
  - CLEAR_VAL constant (0)
- Single module with no sub-module. The clear sequencer reuses the sram_addr register as its counter.

Test Plan:
- Basic write/read: write 0xDEADBEEF to 0x05 -> sram_we=1 for one cycle with sram_addr=0x05, sram_wdata=0xDEADBEEF. Then read 0x05 -> rsp_valid 2 cycles after accept, rsp_rdata=0xDEADBEEF.
- Walking pattern: write addr i=0..255 with bits (i%32) and (31-i%32) set, then read all 256 back -> every rsp_rdata matches (e.g. addr 3 = 0x10000008).
- Backpressure: read with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0. Release -> one beat, then req_ready=1 next cycle.
- Back-to-back: req_valid held high with writes to 0x10 then 0x11 -> second accept exactly 2 cycles after first, no write lost.
- Reset mid-read: assert rst_n=0 in READ -> rsp_valid=0 and sram_we=0 without a clock edge. After release, req_ready=1 and no stale response appears.
- MEM_CLEAR_EN: write 0xFFFFFFFF to 0x80, then reset -> init_busy high 256 cycles, req_ready=0 throughout, read 0x80 returns 0x00000000.
